demux1to4_seq: RTL and testbench
================================

DEMUX1TO4_SEQ -- requirements
Module: demux1to4_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of input and each output channel.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream word present.
REQ-005 SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  word to route.
REQ-007 SHALL have ports: S0  input  1 and S1  input  1  channel select; sampled with in_data.
REQ-008 SHALL have ports: out_valid_A/B/C/D  output  1 each  channel holds a word.
REQ-009 SHALL have ports: out_ready_A/B/C/D  input  1 each  downstream of that channel takes the word.
REQ-010 SHALL have ports: out_data_A/B/C/D  output  WIDTH each  channel holding register.
REQ-011 SHALL have ports: cnt_A/B/C/D  output  8 each  saturating count of words delivered per channel.

Function
REQ-012 SHALL route select codes as follows: S0=0,S1=0 -> A; S0=0,S1=1 -> B; S0=1,S1=0 -> C; S0=1,S1=1 -> D.
REQ-013 Each channel SHALL be a one-entry holding register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 Input transfer SHALL occur when in_valid && in_ready at a rising edge; accept-to-out_valid latency is exactly 1 cycle.
REQ-015 in_ready SHALL be combinational: 1 iff the selected channel is EMPTY, or it is FULL with its out_ready=1 in the same cycle (pass-through refill).
REQ-016 Output transfer SHALL occur on channel X when out_valid_X && out_ready_X; X goes FULL->EMPTY unless refilled in the same cycle.
REQ-017 Simultaneous drain and refill of the same channel SHALL leave it FULL with the new word and no bubble.
REQ-018 Unselected channels SHALL never change out_data and SHALL drain independently; up to four output transfers per cycle are legal.
REQ-019 out_data_X SHALL remain stable while out_valid_X=1 and out_ready_X=0.
REQ-020 cnt_X SHALL increment by 1 on each output transfer on X and saturate at 255 (no wrap).
REQ-021 in_data, S0 and S1 SHALL be ignored when in_valid=0; no channel changes state.
REQ-022 Words SHALL be delivered on each channel in acceptance order; none dropped or duplicated.

Reset
REQ-023 While rst=1 at a rising edge, all channels SHALL go EMPTY, out_valid_X=0, out_data_X=0 and cnt_X=0.
REQ-024 in_ready SHALL be 0 while rst=1; a word presented during reset SHALL NOT be accepted.
REQ-025 Reset asserted mid-operation SHALL discard all held words; the first accept after rst falls occurs no earlier than the next edge.

Structure
REQ-026 Channel-index constants (CH_A=0..CH_D=3) and the EMPTY/FULL state encoding SHALL reside in a shared package demux_pkg.
REQ-027 One sub-module, demux_chan_reg (holding register, state bit and saturating counter), SHALL be instantiated four times.
REQ-028 Select decode SHALL be a single 2-to-4 decode of {S0,S1} shared by data enable and ready mux.

Verification
REQ-029 Reset, then in_data=0x11 with S0=0,S1=0, in_valid=1 for 1 cycle, all out_ready=1 -> out_valid_A=1 with out_data_A=0x11 next cycle only; cnt_A=1.
REQ-030 out_ready_C=0, send 0x33 then 0x44 to C -> first accepted, in_ready=0 for the second until out_ready_C=1; out_data_C holds 0x33 throughout the stall.
REQ-031 Channel D FULL, out_ready_D=1 and a new word 0x55 to D in the same cycle -> in_ready=1, D stays FULL with 0x55, cnt_D increments by 1.
REQ-032 Back-to-back words 0xA0..0xA3 cycling A,B,C,D with all ready -> one word per cycle, each on the correct channel, no bubbles.
REQ-033 300 transfers on B -> cnt_B reads 255 and stays 255.
REQ-034 rst=1 while A and C are FULL -> next cycle all out_valid=0, all cnt=0, in_ready=0 during reset.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 sequential demux: channel indices,
// per-channel holding state encoding and the select decoder.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;
  localparam int CH_D   = 3;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } chan_state_e;

  // {S0,S1} is the channel index directly: 00->A, 01->B, 10->C, 11->D.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: a single-entry holding register with EMPTY/FULL state
// and a saturating count of words delivered downstream.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_valid,
  output logic             o_open,
  output logic [WIDTH-1:0] o_data,
  output logic [7:0]       o_cnt
);

  chan_state_e      r_state;
  logic [WIDTH-1:0] r_data;
  logic [7:0]       r_cnt;
  logic             w_drain;

  assign w_drain = (r_state == ST_FULL) && i_out_ready;
  // Open means a word may be written this cycle, including refill while draining.
  assign o_open  = (r_state == ST_EMPTY) || i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load) begin
        r_state <= ST_FULL;
        r_data  <= i_data;
      end else if (w_drain) begin
        r_state <= ST_EMPTY;
      end
      if (w_drain && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_valid = (r_state == ST_FULL);
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux1to4_seq.sv
// Routes a valid/ready input stream to one of four independently drained
// holding registers selected by {S0,S1}.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, ready may depend on valid-side state.
module demux1to4_seq
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             S0,
  input  logic             S1,
  output logic             out_valid_A,
  output logic             out_valid_B,
  output logic             out_valid_C,
  output logic             out_valid_D,
  input  logic             out_ready_A,
  input  logic             out_ready_B,
  input  logic             out_ready_C,
  input  logic             out_ready_D,
  output logic [WIDTH-1:0] out_data_A,
  output logic [WIDTH-1:0] out_data_B,
  output logic [WIDTH-1:0] out_data_C,
  output logic [WIDTH-1:0] out_data_D,
  output logic [7:0]       cnt_A,
  output logic [7:0]       cnt_B,
  output logic [7:0]       cnt_C,
  output logic [7:0]       cnt_D
);

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_open;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_out_ready;
  logic [WIDTH-1:0]  w_data [NUM_CH];
  logic [7:0]        w_cnt  [NUM_CH];

  // One decode feeds both the ready mux and the per-channel load enables.
  assign w_sel       = sel_decode({S0, S1});
  assign w_out_ready = {out_ready_D, out_ready_C, out_ready_B, out_ready_A};
  assign in_ready    = !rst && |(w_sel & w_open);
  assign w_load      = w_sel & {NUM_CH{in_valid && in_ready}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load[g]),
      .i_data      (in_data),
      .i_out_ready (w_out_ready[g]),
      .o_valid     (w_valid[g]),
      .o_open      (w_open[g]),
      .o_data      (w_data[g]),
      .o_cnt       (w_cnt[g])
    );
  end

  assign out_valid_A = w_valid[CH_A];
  assign out_valid_B = w_valid[CH_B];
  assign out_valid_C = w_valid[CH_C];
  assign out_valid_D = w_valid[CH_D];
  assign out_data_A  = w_data[CH_A];
  assign out_data_B  = w_data[CH_B];
  assign out_data_C  = w_data[CH_C];
  assign out_data_D  = w_data[CH_D];
  assign cnt_A       = w_cnt[CH_A];
  assign cnt_B       = w_cnt[CH_B];
  assign cnt_C       = w_cnt[CH_C];
  assign cnt_D       = w_cnt[CH_D];

endmodule

// File: tb/tb_demux1to4_seq.sv
// Bench for demux1to4_seq: directed scenarios plus random traffic checked
// against a per-channel queue model of delivered words and counts.
module tb_demux1to4_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         S0, S1;
  logic [3:0]   ordy;
  logic [3:0]   ov;
  logic [W-1:0] od [4];
  logic [7:0]   cnt [4];

  int total = 0;
  int bad   = 0;

  // Reference model: words waiting on each channel, last word written, deliveries.
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] exp_data [4];
  int           exp_cnt [4];

  always #5 clk = ~clk;

  demux1to4_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .S0          (S0),
    .S1          (S1),
    .out_valid_A (ov[0]),
    .out_valid_B (ov[1]),
    .out_valid_C (ov[2]),
    .out_valid_D (ov[3]),
    .out_ready_A (ordy[0]),
    .out_ready_B (ordy[1]),
    .out_ready_C (ordy[2]),
    .out_ready_D (ordy[3]),
    .out_data_A  (od[0]),
    .out_data_B  (od[1]),
    .out_data_C  (od[2]),
    .out_data_D  (od[3]),
    .cnt_A       (cnt[0]),
    .cnt_B       (cnt[1]),
    .cnt_C       (cnt[2]),
    .cnt_D       (cnt[3])
  );

  function automatic int sel_idx();
    return {30'd0, S0, S1};
  endfunction

  function automatic logic m_ready();
    int s;
    s = sel_idx();
    return !rst && ((exp_q[s].size() == 0) || ordy[s]);
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (exp_q[c].size() != 0);
    return v;
  endfunction

  // Advance one clock; the model applies the same edge using the stable inputs.
  task automatic tick();
    logic acc;
    int   s;
    @(posedge clk);
    acc = in_valid && m_ready();
    s   = sel_idx();
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[c].delete();
        exp_data[c] = '0;
        exp_cnt[c]  = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (exp_q[c].size() != 0 && ordy[c]) begin
          void'(exp_q[c].pop_front());
          if (exp_cnt[c] < 255) exp_cnt[c]++;
        end
        if (acc && s == c) begin
          exp_q[c].push_back(in_data);
          exp_data[c] = in_data;
        end
      end
    end
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_setup(input logic [1:0] ch, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    {S0, S1} = ch;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send_setup(2'd0, 8'h99);
    ordy = 4'h0;
    settle();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready actual=%b required=0", in_ready);
    end
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ov[c] !== 1'b0 || od[c] !== '0 || cnt[c] !== 8'd0) begin
        bad++;
        $display("FAIL reset_state ch%0d actual v=%b d=%h c=%0d required v=0 d=00 c=0",
                 c, ov[c], od[c], cnt[c]);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    settle();
  endtask

  task automatic test_single();
    ordy = 4'hF;
    send_setup(2'b00, 8'h11);
    settle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready actual=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    settle();
    total++;
    if (ov !== 4'b0001 || od[0] !== 8'h11) begin
      bad++; $display("FAIL single_out actual v=%b dA=%h required v=0001 dA=11", ov, od[0]);
    end
    tick();
    total++;
    if (ov[0] !== 1'b0 || cnt[0] !== 8'd1) begin
      bad++; $display("FAIL single_drain actual vA=%b cA=%0d required vA=0 cA=1", ov[0], cnt[0]);
    end
  endtask

  task automatic test_stall();
    ordy = 4'b1011;
    send_setup(2'b10, 8'h33);
    settle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_first_ready actual=%b required=1", in_ready);
    end
    tick();
    send_setup(2'b10, 8'h44);
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if (in_ready !== 1'b0 || ov[2] !== 1'b1 || od[2] !== 8'h33) begin
        bad++;
        $display("FAIL stall_hold cyc%0d actual rdy=%b vC=%b dC=%h required rdy=0 vC=1 dC=33",
                 i, in_ready, ov[2], od[2]);
      end
      tick();
    end
    ordy = 4'hF;
    settle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release_ready actual=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    settle();
    total++;
    if (ov[2] !== 1'b1 || od[2] !== 8'h44 || cnt[2] !== 8'(exp_cnt[2])) begin
      bad++;
      $display("FAIL stall_second actual vC=%b dC=%h cC=%0d required vC=1 dC=44 cC=%0d",
               ov[2], od[2], cnt[2], exp_cnt[2]);
    end
    tick();
  endtask

  task automatic test_refill();
    int pre;
    ordy = 4'b0111;
    send_setup(2'b11, 8'h50);
    tick();
    ordy = 4'hF;
    send_setup(2'b11, 8'h55);
    pre = exp_cnt[3];
    settle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL refill_ready actual=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    settle();
    total++;
    if (ov[3] !== 1'b1 || od[3] !== 8'h55 || cnt[3] !== 8'(pre + 1)) begin
      bad++;
      $display("FAIL refill_out actual vD=%b dD=%h cD=%0d required vD=1 dD=55 cD=%0d",
               ov[3], od[3], cnt[3], pre + 1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    ordy = 4'hF;
    for (int i = 0; i < 4; i++) begin
      send_setup(2'(i), 8'hA0 + 8'(i));
      settle();
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready word%0d actual=%b required=1", i, in_ready);
      end
      tick();
      total++;
      if (ov !== (4'b0001 << i) || od[i] !== 8'hA0 + 8'(i)) begin
        bad++;
        $display("FAIL b2b_out word%0d actual v=%b d=%h required v=%b d=%h",
                 i, ov, od[i], 4'b0001 << i, 8'hA0 + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    ordy = 4'hF;
    for (int i = 0; i < 300; i++) begin
      send_setup(2'b01, 8'($urandom));
      tick();
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (cnt[1] !== 8'd255 || exp_cnt[1] != 255) begin
      bad++; $display("FAIL sat_cnt actual=%0d required=255", cnt[1]);
    end
    tick(); tick();
    total++;
    if (cnt[1] !== 8'd255) begin
      bad++; $display("FAIL sat_hold actual=%0d required=255", cnt[1]);
    end
  endtask

  task automatic test_mid_reset();
    ordy = 4'h0;
    send_setup(2'b00, 8'h61);
    tick();
    send_setup(2'b10, 8'h63);
    tick();
    in_valid = 1'b0;
    settle();
    total++;
    if (ov !== 4'b0101) begin
      bad++; $display("FAIL midrst_pre actual v=%b required v=0101", ov);
    end
    rst = 1'b1;
    send_setup(2'b01, 8'h77);
    settle();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_ready actual=%b required=0", in_ready);
    end
    tick();
    total++;
    if (ov !== 4'b0000 || cnt[0] !== 8'd0 || cnt[1] !== 8'd0 || cnt[2] !== 8'd0 ||
        cnt[3] !== 8'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state actual v=%b cnt=%0d/%0d/%0d/%0d rdy=%b required v=0000 cnt=0 rdy=0",
               ov, cnt[0], cnt[1], cnt[2], cnt[3], in_ready);
    end
    rst = 1'b0;
    settle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_release actual=%b required=1", in_ready);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (ov !== 4'b0000) begin
      bad++; $display("FAIL midrst_no_accept actual v=%b required v=0000", ov);
    end
  endtask

  task automatic test_random();
    logic [3:0] ev;
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      S0       = 1'($urandom);
      S1       = 1'($urandom);
      ordy     = 4'($urandom);
      settle();
      total++;
      if (in_ready !== m_ready()) begin
        bad++; $display("FAIL rand_ready cyc%0d actual=%b required=%b", i, in_ready, m_ready());
      end
      tick();
      ev = m_valid();
      for (int c = 0; c < 4; c++) begin
        total++;
        if (ov[c] !== ev[c] || od[c] !== exp_data[c] || cnt[c] !== 8'(exp_cnt[c]) ||
            (ev[c] && od[c] !== exp_q[c][0])) begin
          bad++;
          $display("FAIL rand_chan cyc%0d ch%0d actual v=%b d=%h c=%0d required v=%b d=%h c=%0d",
                   i, c, ov[c], od[c], cnt[c], ev[c], exp_data[c], exp_cnt[c]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    S0       = 1'b0;
    S1       = 1'b0;
    ordy     = 4'h0;
    for (int c = 0; c < 4; c++) begin
      exp_data[c] = '0;
      exp_cnt[c]  = 0;
    end
    #2;
    test_reset();
    test_single();
    test_stall();
    test_refill();
    test_back_to_back();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
